// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider controller for DIV/DIVU in the EX stage.
// Stalls the pipeline until the {remainder, quotient} result is ready for HI/LO.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_div,
  input  logic                 signed_div,
  input  logic                 annul,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stall_div
);

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    ON,
    END
  } state_t;

  state_t state, state_next;

  logic [5:0]       cnt;
  logic [WIDTH-1:0] dvd;      // remaining dividend bits, quotient shifts in at the LSB
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign accept    = start_div & ~annul;
  assign last_iter = (cnt == 6'(WIDTH - 1));
  assign stall_div = start_div & ~ready;

  always_comb begin
    abs_a = opdata1;
    abs_b = opdata2;
    if (signed_div && opdata1[WIDTH-1]) abs_a = -opdata1;
    if (signed_div && opdata2[WIDTH-1]) abs_b = -opdata2;
  end

  // One restoring step: trial subtract of the divisor from {rem, next dividend bit}.
  always_comb begin
    trial    = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
    qbit     = ~trial[WIDTH];
    rem_step = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
    dvd_step = {dvd[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = (opdata2 == '0) ? DIVZERO : ON;
      end
      DIVZERO: begin
        state_next = annul ? IDLE : END;
      end
      ON: begin
        if (annul)          state_next = IDLE;
        else if (last_iter) state_next = END;
      end
      END: begin
        if (annul || !start_div) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            dvd   <= abs_a;
            dvs   <= abs_b;
            rem   <= '0;
            cnt   <= '0;
            neg_r <= signed_div & opdata1[WIDTH-1];
            neg_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          end
        end
        DIVZERO: begin
          if (!annul) begin
            dvd <= '0;
            rem <= '0;
          end
        end
        ON: begin
          if (!annul) begin
            cnt <= cnt + 6'd1;
            // Sign fix-up is folded into the final iteration so END only copies.
            if (last_iter) begin
              dvd <= neg_q ? -dvd_step : dvd_step;
              rem <= neg_r ? -rem_step : rem_step;
            end else begin
              dvd <= dvd_step;
              rem <= rem_step;
            end
          end
        end
        END: begin
          if (start_div && !annul) begin
            result <= {rem, dvd};
            ready  <= 1'b1;
          end
        end
        default: ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table, random model cases and
// hand-written annul/reset sequences, with a queue-based scoreboard.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_div;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_div;

  div_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_div  (start_div),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_div  (stall_div)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Drives one request, scrambles the operands after sampling, waits for ready.
  // pre_annul: first request cycle carries annul (must be ignored).
  // end_annul: leave END via annul instead of dropping start_div.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input string name,
                         input logic pre_annul, input logic end_annul);
    int          n;
    logic        stall_ok;
    exp_t        e;
    logic [63:0] held;
    @(negedge clk);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start_div  = 1'b1;
    annul      = pre_annul;
    if (pre_annul) begin
      @(negedge clk);
      annul = 1'b0;
    end
    sb.push_back('{res: exp, lat: lat});
    #1;
    stall_ok = (stall_div === 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~sgn;
      end
      if (ready !== 1'b1 && stall_div !== 1'b1) stall_ok = 1'b0;
    end while (ready !== 1'b1 && n < 100);
    e = sb.pop_front();
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: ready not seen after %0d cycles, required at %0d", name, n, e.lat);
    end else begin
      check64({name, " result"}, result, e.res);
      check_int({name, " latency"}, n, e.lat);
      check_int({name, " stall during op"}, int'(stall_ok), 1);
      check_int({name, " stall in ready cycle"}, int'(stall_div), 0);
    end
    held = result;
    if (end_annul) annul = 1'b1;
    else           start_div = 1'b0;
    @(negedge clk);
    check_int({name, " ready after leaving END"}, int'(ready), 0);
    check64({name, " result frozen"}, result, held);
    start_div = 1'b0;
    annul     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]        ra, rb;
    logic signed [31:0] qs, rs;
    logic [31:0]        qu, ru;
    logic [63:0]        exp, held;
    logic               sgn, seen;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 34};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 34};
    vecs[3]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  64'hFFFFFFFF_00000003, 34};
    vecs[4]  = '{1'b0, 32'h00001234,  32'd0,         64'h0, 3};
    vecs[5]  = '{1'b1, 32'h00001234,  32'd0,         64'h0, 3};
    vecs[6]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 34};
    vecs[7]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 34};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 34};
    vecs[9]  = '{1'b0, 32'd0,         32'd5,         64'h0, 34};
    vecs[10] = '{1'b1, 32'h80000000,  32'd1,         64'h00000000_80000000, 34};
    vecs[11] = '{1'b0, 32'd5,         32'hFFFFFFFF,  64'h00000005_00000000, 34};

    resetn     = 1'b0;
    start_div  = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    #12;
    check64("reset result", result, 64'h0);
    check_int("reset ready", int'(ready), 0);
    check_int("reset stall", int'(stall_div), 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++)
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
              $sformatf("vec%0d", i), 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      sgn = (i % 2 == 1);
      ra  = $urandom;
      rb  = (i < 4) ? $urandom_range(1, 1000) : $urandom;
      if (rb == 0) rb = 1;
      if (sgn) begin
        if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
        qs  = $signed(ra) / $signed(rb);
        rs  = $signed(ra) % $signed(rb);
        exp = {rs, qs};
      end else begin
        qu  = ra / rb;
        ru  = ra % rb;
        exp = {ru, qu};
      end
      run_div(sgn, ra, rb, exp, 34, $sformatf("rand%0d", i), 1'b0, 1'b0);
    end

    // annul together with start in IDLE: the first request cycle must be ignored
    run_div(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 34, "annul_in_idle", 1'b1, 1'b0);

    // annul in END returns to IDLE with ready low
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 34, "annul_in_end", 1'b0, 1'b1);

    // annul in the 10th ON cycle aborts without touching result
    held = result;
    @(negedge clk);
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start_div  = 1'b1;
    repeat (10) @(negedge clk);
    annul     = 1'b1;
    start_div = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    check_int("aborted ready stays low", int'(seen), 0);
    check64("aborted result untouched", result, held);
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, "after_annul", 1'b0, 1'b0);

    // asynchronous reset in the middle of ON
    @(negedge clk);
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start_div  = 1'b1;
    repeat (15) @(negedge clk);
    resetn    = 1'b0;
    start_div = 1'b0;
    #1;
    check64("mid-op reset result", result, 64'h0);
    check_int("mid-op reset ready", int'(ready), 0);
    check_int("mid-op reset stall", int'(stall_div), 0);
    @(negedge clk);
    resetn = 1'b1;
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, "after_reset", 1'b0, 1'b0);

    check_int("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divider controller for the EX stage, sequencing DIV/DIVU next to the ALU. It accepts a start request from EX, latches the operands and runs a 32-iteration restoring division with signed fix-up. It holds the pipeline through `stall_div` until the 64-bit result is ready. The result is delivered in HI/LO layout {remainder, quotient} for the hilo write path.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_div`  in  1  request from EX; held high until `ready` is seen.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `start_div` in IDLE.
- `annul`  in  1  flush (exception/branch kill); aborts the operation.
- `opdata1`  in  32  dividend; sampled in IDLE.
- `opdata2`  in  32  divisor; sampled in IDLE.
- `result`  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}.
- `ready`  out  1  result valid.
- `stall_div`  out  1  pipeline stall request.

## Operation
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - If `start_div & ~annul`: latch `signed_div` and the operands.
  - In signed mode, take absolute values of the operands and record sign(dividend) and sign(dividend) XOR sign(divisor).
  - Divisor == 0 → DIVZERO. Otherwise clear the 6-bit counter and go to ON.
- ON: one quotient bit per cycle, MSB first.
  - Form the 33-bit trial = {partial_rem[31:0], next dividend bit} − {1'b0, |divisor|}.
  - If the trial is non-negative: partial_rem ← trial, qbit = 1. Otherwise shift with qbit = 0.
  - Increment the counter. After the 32nd iteration → END.
- Sign fix-up, applied when entering END:
  - Quotient is negated (two's complement) if the sign XOR is set.
  - Remainder takes the sign of the dividend.
  - Unsigned mode: no fix-up.
- DIVZERO: one cycle; load `result` = 64'h0 → END. The CPU raises no exception.
- END:
  - `ready` = 1 and `result` is held stable.
  - When `start_div` drops → IDLE on the next edge; `ready` → 0 and `result` stays frozen until the next start.
- Operand changes after sampling are ignored until the next IDLE.
- Signed 0x80000000 / 0xFFFFFFFF: |a| = 2^31, |b| = 1, so quotient = 0x80000000 and remainder = 0. No overflow flag.
- `stall_div` = `start_div & ~ready`, combinational. It is high from the request cycle until the `ready` cycle.

## Timing
- Reset (async, `resetn` = 0): state = IDLE, `result` = 0, `ready` = 0, counter = 0, internal regs = 0. `stall_div` follows its equation, so it is 0 while `start_div` = 0.
- Start sampled at edge T (in IDLE):
  - Normal divide: ON occupies T+1..T+32 and END is entered at T+33. `ready` is registered and high in the cycle after edge T+33. Total latency is 34 cycles from the request cycle.
  - Divide by zero: DIVZERO at T+1, END at T+2.
- `annul` while in DIVZERO or ON → IDLE at the next edge. `ready` never asserts and the partial `result` is not updated.
- `annul` in END → IDLE at the next edge with `ready` = 0.
- `annul` together with `start_div` in IDLE: the request is ignored.
- `start_div` must stay high until `ready`. A drop during ON is not a legal abort; use `annul` to abort.
- Back-to-back requests: a new request is accepted only after the controller returns to IDLE. That requires at least one cycle with `start_div` = 0.
- Reset asserted mid-operation: return to IDLE immediately, with outputs as at reset.

## Test plan
- DIVU 100 / 7:
  - `result` = 64'h00000002_0000000E.
  - `ready` rises exactly 34 cycles after the request cycle.
  - `stall_div` = 1 throughout, then 0 in the `ready` cycle.
- DIV −7 / 2 → 64'hFFFFFFFF_FFFFFFFD. DIV 7 / −2 → 64'h00000001_FFFFFFFD. DIV −7 / −2 → 64'hFFFFFFFF_00000003.
- Divide by zero, both modes (e.g. 0x1234 / 0) → `result` = 0, `ready` at the third cycle after the request.
- 0x80000000 / 0xFFFFFFFF:
  - Signed → 64'h00000000_80000000.
  - Unsigned → 64'h80000000_00000000.
  - DIVU 0xFFFFFFFF / 1 → 64'h00000000_FFFFFFFF.
- `annul` pulsed at the 10th ON cycle:
  - State returns to IDLE, `ready` stays 0 for 50 cycles.
  - A following DIVU 9 / 3 → 64'h00000000_00000003 with full latency.
- `resetn` asserted mid-ON: outputs are 0 immediately (asynchronous). After release, a new request completes correctly.
- Operands changed after the start edge: `result` reflects the sampled values.
